// File: rtl/ucsbece154_icache.sv
// 2-way set-associative, blocking, read-only instruction cache with critical-word-first fill.
// Define ICACHE_PERF_EN to add the HitCount/MissCount outputs.
module ucsbece154_icache #(
    parameter int unsigned NUM_SETS    = 8,
    parameter int unsigned NUM_WAYS    = 2,
    parameter int unsigned BLOCK_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReadEnable,
    input  logic [31:0] ReadAddress,
    output logic [31:0] Instruction,
    output logic        Ready,
    output logic        MemReadRequest,
    output logic [31:0] MemReadAddress,
`ifdef ICACHE_PERF_EN
    output logic [31:0] HitCount,
    output logic [31:0] MissCount,
`endif
    input  logic [31:0] MemDataIn,
    input  logic        MemDataReady
);

    localparam int unsigned OFF_W = $clog2(BLOCK_WORDS);
    localparam int unsigned IDX_W = $clog2(NUM_SETS);
    localparam int unsigned WAY_W = $clog2(NUM_WAYS);
    localparam int unsigned TAG_W = 30 - OFF_W - IDX_W;
    localparam int unsigned CNT_W = $clog2(BLOCK_WORDS + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FILL} state_e;

    state_e                            state_q, state_d;
    logic [29:0]                       addr_q, addr_d;
    logic [WAY_W-1:0]                  victim_q, victim_d;
    logic [OFF_W-1:0]                  ptr_q, ptr_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q, valid_d;
    logic [NUM_SETS-1:0][WAY_W-1:0]    lru_q, lru_d;

    logic [TAG_W-1:0] tag_q  [NUM_WAYS][NUM_SETS];
    logic [31:0]      data_q [NUM_WAYS][NUM_SETS][BLOCK_WORDS];

    logic [OFF_W-1:0] req_off, fill_off, data_off;
    logic [IDX_W-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0] req_tag, fill_tag;
    logic [WAY_W-1:0] hit_way, miss_victim;
    logic             hit, data_we, tag_we;
    logic             unused_addr_bits;

    assign req_off  = ReadAddress[2 +: OFF_W];
    assign req_idx  = ReadAddress[2 + OFF_W +: IDX_W];
    assign req_tag  = ReadAddress[2 + OFF_W + IDX_W +: TAG_W];
    assign fill_off = addr_q[0 +: OFF_W];
    assign fill_idx = addr_q[OFF_W +: IDX_W];
    assign fill_tag = addr_q[OFF_W + IDX_W +: TAG_W];
    assign unused_addr_bits = ^ReadAddress[1:0];

    assign MemReadRequest = (state_q == S_REQ);
    assign MemReadAddress = {addr_q, 2'b00};

    // Tag compare across both ways of the requested set
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[w][req_idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Prefer an empty way before evicting the least recently used one
    always_comb begin
        if (!valid_q[req_idx][0])
            miss_victim = WAY_W'(0);
        else if (!valid_q[req_idx][1])
            miss_victim = WAY_W'(1);
        else
            miss_victim = lru_q[req_idx];
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        victim_d    = victim_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        lru_d       = lru_q;
        data_we     = 1'b0;
        data_off    = ptr_q;
        tag_we      = 1'b0;
        Ready       = 1'b0;
        Instruction = '0;
        unique case (state_q)
            S_IDLE: begin
                if (ReadEnable) begin
                    if (hit) begin
                        Ready          = 1'b1;
                        Instruction    = data_q[hit_way][req_idx][req_off];
                        lru_d[req_idx] = ~hit_way;
                    end else begin
                        addr_d                       = ReadAddress[31:2];
                        victim_d                     = miss_victim;
                        valid_d[req_idx][miss_victim] = 1'b0;
                        state_d                      = S_REQ;
                    end
                end
            end
            S_REQ: state_d = S_WAIT;
            S_WAIT: begin
                if (MemDataReady) begin
                    data_we     = 1'b1;
                    data_off    = fill_off;
                    tag_we      = 1'b1;
                    ptr_d       = fill_off + OFF_W'(1);
                    cnt_d       = CNT_W'(1);
                    Ready       = 1'b1;
                    Instruction = MemDataIn;
                    state_d     = S_FILL;
                end
            end
            S_FILL: begin
                // A gap in the burst abandons the fill with the line still invalid
                state_d = S_IDLE;
                if (MemDataReady) begin
                    data_we = 1'b1;
                    ptr_d   = ptr_q + OFF_W'(1);
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(BLOCK_WORDS)) begin
                        valid_d[fill_idx][victim_q] = 1'b1;
                        lru_d[fill_idx]             = ~victim_q;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            victim_q <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= '0;
            lru_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            victim_q <= victim_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            lru_q    <= lru_d;
        end
    end

    // Tag and data arrays carry no reset; validity is tracked separately
    always_ff @(posedge clk) begin
        if (data_we)
            data_q[victim_q][fill_idx][data_off] <= MemDataIn;
        if (tag_we)
            tag_q[victim_q][fill_idx] <= fill_tag;
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if ((state_q == S_IDLE) && ReadEnable) begin
            if (hit)
                hit_cnt_d = hit_cnt_q + 32'd1;
            else
                miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign HitCount  = hit_cnt_q;
    assign MissCount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_ucsbece154_icache.sv
// Randomized self-checking bench for ucsbece154_icache against a recency-list cache model.
// Counter outputs are checked when ICACHE_PERF_EN is defined.
module tb_ucsbece154_icache;

    logic        clk = 1'b0;
    logic        reset;
    logic        ReadEnable;
    logic [31:0] ReadAddress;
    logic [31:0] Instruction;
    logic        Ready;
    logic        MemReadRequest;
    logic [31:0] MemReadAddress;
    logic [31:0] MemDataIn;
    logic        MemDataReady;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_count, miss_count;
`endif

    ucsbece154_icache dut (
        .clk            (clk),
        .reset          (reset),
        .ReadEnable     (ReadEnable),
        .ReadAddress    (ReadAddress),
        .Instruction    (Instruction),
        .Ready          (Ready),
        .MemReadRequest (MemReadRequest),
        .MemReadAddress (MemReadAddress),
`ifdef ICACHE_PERF_EN
        .HitCount       (hit_count),
        .MissCount      (miss_count),
`endif
        .MemDataIn      (MemDataIn),
        .MemDataReady   (MemDataReady)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    // Per set: resident block tags ordered most- then least-recently used
    logic [24:0] m_mru [8];
    logic [24:0] m_lru [8];
    int          m_cnt [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    function automatic bit model_hit(input int s, input logic [24:0] tg);
        return (m_cnt[s] >= 1 && m_mru[s] == tg) || (m_cnt[s] == 2 && m_lru[s] == tg);
    endfunction

    task automatic model_touch(input int s, input logic [24:0] tg);
        if (m_cnt[s] == 2 && m_lru[s] == tg) begin
            m_lru[s] = m_mru[s];
            m_mru[s] = tg;
        end
    endtask

    task automatic model_fill(input int s, input logic [24:0] tg, input bit full);
        if (m_cnt[s] == 2) m_cnt[s] = 1;
        if (full) begin
            m_lru[s] = m_mru[s];
            m_mru[s] = tg;
            m_cnt[s]++;
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        ReadEnable   = 1'b0;
        MemDataReady = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(Ready), 32'd0);
        chk("rst_instr", Instruction, 32'd0);
        chk("rst_req", 32'(MemReadRequest), 32'd0);
        chk("rst_addr", MemReadAddress, 32'd0);
`ifdef ICACHE_PERF_EN
        chk("rst_hitcnt", hit_count, 32'd0);
        chk("rst_misscnt", miss_count, 32'd0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    // One fetch; on a miss the bench plays memory: delay, then nbeats critical-word-first beats
    task automatic do_read(input logic [31:0] addr, input int delay, input int nbeats,
                           input int rst_beat, output logic was_hit);
        logic [31:0] wa, ba;
        logic [24:0] tg;
        int          s;
        bit          exp_hit, rst_seen;
        wa       = {addr[31:2], 2'b00};
        tg       = addr[31:7];
        s        = int'(addr[6:4]);
        exp_hit  = model_hit(s, tg);
        rst_seen = 1'b0;
        ReadEnable  = 1'b1;
        ReadAddress = addr;
        @(negedge clk);
        was_hit = Ready;
        if (exp_hit) begin
            chk("hit_ready", 32'(Ready), 32'd1);
            chk("hit_data", Instruction, mem_word(wa));
            chk("hit_noreq", 32'(MemReadRequest), 32'd0);
            model_touch(s, tg);
            exp_hits++;
            @(posedge clk); #1;
            ReadEnable = 1'b0;
        end else begin
            chk("miss_ready", 32'(Ready), 32'd0);
            exp_misses++;
            @(posedge clk); #1;
            @(negedge clk);
            chk("req_pulse", 32'(MemReadRequest), 32'd1);
            chk("req_addr", MemReadAddress, wa);
            @(posedge clk); #1;
            for (int d = 0; d < delay; d++) begin
                @(negedge clk);
                chk("wait_ready", 32'(Ready), 32'd0);
                chk("wait_noreq", 32'(MemReadRequest), 32'd0);
                @(posedge clk); #1;
            end
            for (int b = 0; b < nbeats; b++) begin
                ba = {wa[31:4], 2'(wa[3:2] + 2'(b)), 2'b00};
                MemDataReady = 1'b1;
                MemDataIn    = mem_word(ba);
                if (b == rst_beat) begin
                    reset    = 1'b1;
                    rst_seen = 1'b1;
                end
                @(negedge clk);
                if (b == rst_beat) begin
                    chk("midrst_ready", 32'(Ready), 32'd0);
                    chk("midrst_addr", MemReadAddress, 32'd0);
                end else if (b == 0) begin
                    chk("fwd_ready", 32'(Ready), 32'd1);
                    chk("fwd_data", Instruction, mem_word(wa));
                end else begin
                    chk("fill_ready", 32'(Ready), 32'd0);
                    if (!rst_seen) chk("fill_addr", MemReadAddress, wa);
                end
                chk("beat_noreq", 32'(MemReadRequest), 32'd0);
                @(posedge clk); #1;
                ReadEnable = 1'b0;
                reset      = 1'b0;
            end
            MemDataReady = 1'b0;
            MemDataIn    = $urandom;
            if (rst_seen) begin
                model_reset();
            end else begin
                if (nbeats < 4) begin
                    @(negedge clk);
                    chk("trunc_ready", 32'(Ready), 32'd0);
                    @(posedge clk); #1;
                end
                model_fill(s, tg, nbeats == 4);
            end
        end
    endtask

    task automatic idle_beats(input int n);
        for (int i = 0; i < n; i++) begin
            MemDataReady = 1'b1;
            MemDataIn    = $urandom;
            @(negedge clk);
            chk("idle_ready", 32'(Ready), 32'd0);
            chk("idle_noreq", 32'(MemReadRequest), 32'd0);
            @(posedge clk); #1;
        end
        MemDataReady = 1'b0;
    endtask

    initial begin
        logic        h;
        logic [31:0] r, a;
        reset       = 1'b1;
        ReadEnable  = 1'b0;
        ReadAddress = '0;
        MemDataIn   = '0;
        MemDataReady = 1'b0;
        do_reset();

        // Cold miss with long memory latency, then hits on the rest of the line
        do_read(32'h0001_0004, 40, 4, -1, h); chk("t1_miss", 32'(h), 32'd0);
        do_read(32'h0001_000C, 0, 4, -1, h);  chk("t2_hit", 32'(h), 32'd1);
        do_read(32'h0001_0000, 0, 4, -1, h);  chk("t2_hit0", 32'(h), 32'd1);
        do_read(32'h0001_0008, 0, 4, -1, h);  chk("t2_hit2", 32'(h), 32'd1);

        // Conflict in set 0 evicts the LRU line
        do_reset();
        do_read(32'h0001_0000, 2, 4, -1, h); chk("t3_miss_a", 32'(h), 32'd0);
        do_read(32'h0001_0080, 1, 4, -1, h); chk("t3_miss_b", 32'(h), 32'd0);
        do_read(32'h0001_0000, 0, 4, -1, h); chk("t3_hit_a", 32'(h), 32'd1);
        do_read(32'h0001_0100, 3, 4, -1, h); chk("t3_miss_c", 32'(h), 32'd0);
        do_read(32'h0001_0000, 0, 4, -1, h); chk("t3_rehit_a", 32'(h), 32'd1);
        do_read(32'h0001_0080, 0, 4, -1, h); chk("t3_remiss_b", 32'(h), 32'd0);

        // Critical offset 3 wraps the fill pointer
        do_read(32'h0001_001C, 1, 4, -1, h); chk("t4_miss", 32'(h), 32'd0);
        for (int i = 0; i < 4; i++) begin
            do_read(32'h0001_0010 + 32'(4 * i), 0, 4, -1, h);
            chk("t4_hit", 32'(h), 32'd1);
        end

        // Reset on the second FILL beat
        do_read(32'h0001_0024, 3, 4, 2, h);  chk("t5_miss", 32'(h), 32'd0);
        do_read(32'h0001_0024, 0, 4, -1, h); chk("t5_remiss", 32'(h), 32'd0);

        // Truncated burst leaves the line invalid
        do_reset();
        do_read(32'h0001_0034, 2, 2, -1, h); chk("t6_miss", 32'(h), 32'd0);
        do_read(32'h0001_0034, 1, 4, -1, h); chk("t6_remiss", 32'(h), 32'd0);
`ifdef ICACHE_PERF_EN
        chk("t6_misscnt", miss_count, 32'd2);
        chk("t6_hitcnt", hit_count, 32'd0);
`endif
        idle_beats(3);

        for (int n = 0; n < 400; n++) begin
            r = $urandom;
            a = {25'h200 + 25'(r[1:0]), r[4:2], r[6:5], r[8:7]};
            do_read(a, int'($urandom_range(0, 4)),
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 4, -1, h);
            if (r[15:12] == 4'd0) idle_beats(1);
        end
`ifdef ICACHE_PERF_EN
        @(negedge clk);
        chk("end_hitcnt", hit_count, 32'(exp_hits));
        chk("end_misscnt", miss_count, 32'(exp_misses));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
